// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall hold, flush bubble insertion,
// valid tracking and a saturating stall-cycle counter.
module pipe_stage_reg #(
    parameter int          DATA_W           = 128,
    parameter bit          KEEP_PC_ON_FLUSH = 1'b1,
    parameter int          CNT_W            = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              flush,
    input  logic              cnt_clr,
    input  logic              d_valid,
    input  logic [31:0]       d_instr,
    input  logic [31:0]       d_pc,
    input  logic [4:0]        d_wba,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic              q_bubble,
    output logic [31:0]       q_instr,
    output logic [31:0]       q_pc,
    output logic [4:0]        q_wba,
    output logic [DATA_W-1:0] q_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic              r_valid;
    logic              r_bubble;
    logic [31:0]       r_instr;
    logic [31:0]       r_pc;
    logic [4:0]        r_wba;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic              w_hold;
    logic              w_cnt_sat;
    logic [31:0]       w_flush_pc;

    assign w_hold     = !en && !flush;
    assign w_cnt_sat  = (r_stall_cnt == {CNT_W{1'b1}});
    assign w_flush_pc = KEEP_PC_ON_FLUSH ? d_pc : 32'h0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid     <= 1'b0;
            r_bubble    <= 1'b0;
            r_instr     <= 32'h0;
            r_pc        <= 32'h0;
            r_wba       <= 5'h0;
            r_data      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (flush) begin
                r_valid  <= 1'b0;
                r_bubble <= 1'b1;
                r_instr  <= 32'h0;
                r_pc     <= w_flush_pc;
                r_wba    <= 5'h0;
                r_data   <= '0;
            end else if (en) begin
                r_valid  <= d_valid;
                r_bubble <= 1'b0;
                r_instr  <= d_instr;
                r_pc     <= d_pc;
                // an invalid instruction must never reach a register write
                r_wba    <= d_valid ? d_wba : 5'h0;
                r_data   <= d_data;
            end

            if (cnt_clr) begin
                r_stall_cnt <= '0;
            end else if (w_hold && r_valid && !w_cnt_sat) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign q_valid   = r_valid;
    assign q_bubble  = r_bubble;
    assign q_instr   = r_instr;
    assign q_pc      = r_pc;
    assign q_wba     = r_wba;
    assign q_data    = r_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances share stimulus to cover
// the default build, KEEP_PC_ON_FLUSH=0 and a 4-bit stall counter.
module tb_pipe_stage_reg;

    logic         clk = 1'b0;
    logic         reset, en, flush, cnt_clr, d_valid;
    logic [31:0]  d_instr, d_pc;
    logic [4:0]   d_wba;
    logic [127:0] d_data;

    logic         q0_valid, q0_bubble, q1_valid, q1_bubble, q2_valid, q2_bubble;
    logic [31:0]  q0_instr, q0_pc, q1_instr, q1_pc, q2_instr, q2_pc;
    logic [4:0]   q0_wba, q1_wba, q2_wba;
    logic [127:0] q0_data, q1_data, q2_data;
    logic [15:0]  cnt0, cnt1;
    logic [3:0]   cnt2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(128), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(16)) u0 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_wba(d_wba), .d_data(d_data),
        .q_valid(q0_valid), .q_bubble(q0_bubble), .q_instr(q0_instr), .q_pc(q0_pc),
        .q_wba(q0_wba), .q_data(q0_data), .stall_cnt(cnt0));

    pipe_stage_reg #(.DATA_W(128), .KEEP_PC_ON_FLUSH(1'b0), .CNT_W(16)) u1 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_wba(d_wba), .d_data(d_data),
        .q_valid(q1_valid), .q_bubble(q1_bubble), .q_instr(q1_instr), .q_pc(q1_pc),
        .q_wba(q1_wba), .q_data(q1_data), .stall_cnt(cnt1));

    pipe_stage_reg #(.DATA_W(128), .KEEP_PC_ON_FLUSH(1'b1), .CNT_W(4)) u2 (
        .clk(clk), .reset(reset), .en(en), .flush(flush), .cnt_clr(cnt_clr),
        .d_valid(d_valid), .d_instr(d_instr), .d_pc(d_pc), .d_wba(d_wba), .d_data(d_data),
        .q_valid(q2_valid), .q_bubble(q2_bubble), .q_instr(q2_instr), .q_pc(q2_pc),
        .q_wba(q2_wba), .q_data(q2_data), .stall_cnt(cnt2));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " valid"},  {127'h0, q0_valid},  128'h0);
        chk({tag, " bubble"}, {127'h0, q0_bubble}, 128'h0);
        chk({tag, " instr"},  {96'h0, q0_instr},   128'h0);
        chk({tag, " pc"},     {96'h0, q0_pc},      128'h0);
        chk({tag, " wba"},    {123'h0, q0_wba},    128'h0);
        chk({tag, " data"},   q0_data,             128'h0);
        chk({tag, " cnt"},    {112'h0, cnt0},      128'h0);
        chk({tag, " cnt_w4"}, {124'h0, cnt2},      128'h0);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
        d_valid = 1'b0; d_instr = 32'h0; d_pc = 32'h0; d_wba = 5'h0; d_data = '0;

        step(); step();
        chk_zero("reset");

        // first load
        reset = 1'b0; en = 1'b1; d_valid = 1'b1;
        d_instr = 32'h8C22_0004; d_pc = 32'h0000_3000; d_wba = 5'd2;
        d_data = {16{8'hA5}};
        step();
        chk("load instr",  {96'h0, q0_instr},  128'h8C22_0004);
        chk("load pc",     {96'h0, q0_pc},     128'h3000);
        chk("load wba",    {123'h0, q0_wba},   128'd2);
        chk("load valid",  {127'h0, q0_valid}, 128'd1);
        chk("load bubble", {127'h0, q0_bubble},128'd0);
        chk("load data",   q0_data,            {16{8'hA5}});

        // stall three cycles with changing inputs
        en = 1'b0;
        d_instr = 32'h0000_0001; d_pc = 32'h0000_3004; d_wba = 5'd7; d_data = 128'h1;
        step();
        chk("stall1 instr", {96'h0, q0_instr}, 128'h8C22_0004);
        chk("stall1 cnt",   {112'h0, cnt0},    128'd1);
        d_instr = 32'h2408_0005;
        step();
        chk("stall2 pc",    {96'h0, q0_pc},    128'h3000);
        step();
        chk("stall3 instr", {96'h0, q0_instr}, 128'h8C22_0004);
        chk("stall3 wba",   {123'h0, q0_wba},  128'd2);
        chk("stall3 data",  q0_data,           {16{8'hA5}});
        chk("stall3 cnt",   {112'h0, cnt0},    128'd3);
        chk("stall3 cnt_w4",{124'h0, cnt2},    128'd3);

        en = 1'b1;
        step();
        chk("reload instr", {96'h0, q0_instr}, 128'h2408_0005);
        chk("reload pc",    {96'h0, q0_pc},    128'h3004);
        chk("reload wba",   {123'h0, q0_wba},  128'd7);
        chk("reload data",  q0_data,           128'h1);
        chk("reload cnt",   {112'h0, cnt0},    128'd3);

        // flush together with en=0
        flush = 1'b1; en = 1'b0; d_pc = 32'h0000_3010;
        step();
        chk("flush instr",  {96'h0, q0_instr},  128'h0);
        chk("flush wba",    {123'h0, q0_wba},   128'h0);
        chk("flush data",   q0_data,            128'h0);
        chk("flush valid",  {127'h0, q0_valid}, 128'd0);
        chk("flush bubble", {127'h0, q0_bubble},128'd1);
        chk("flush pc keep",{96'h0, q0_pc},     128'h3010);
        chk("flush cnt",    {112'h0, cnt0},     128'd3);
        chk("flush pc drop",{96'h0, q1_pc},     128'h0);
        chk("flush bubble nokeep", {127'h0, q1_bubble}, 128'd1);

        // hold a bubble: bubble persists, counter idle since not valid
        flush = 1'b0;
        step();
        chk("bubble hold",     {127'h0, q0_bubble}, 128'd1);
        chk("bubble hold pc",  {96'h0, q0_pc},      128'h3010);
        chk("bubble hold cnt", {112'h0, cnt0},      128'd3);

        // invalid load masks write-back address
        en = 1'b1; d_valid = 1'b0; d_wba = 5'd31;
        d_instr = 32'h0000_000C; d_pc = 32'h0000_3020;
        step();
        chk("inv wba",    {123'h0, q0_wba},   128'd0);
        chk("inv valid",  {127'h0, q0_valid}, 128'd0);
        chk("inv bubble", {127'h0, q0_bubble},128'd0);
        chk("inv pc",     {96'h0, q0_pc},     128'h3020);
        chk("inv instr",  {96'h0, q0_instr},  128'h0000_000C);

        // valid load with counter clear, then long hold for saturation
        d_valid = 1'b1; d_wba = 5'd9; d_pc = 32'h0000_3024; cnt_clr = 1'b1;
        step();
        chk("clr load cnt",    {112'h0, cnt0}, 128'd0);
        chk("clr load cnt_w4", {124'h0, cnt2}, 128'd0);
        chk("clr load wba",    {123'h0, q0_wba}, 128'd9);
        cnt_clr = 1'b0; en = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat cnt_w4", {124'h0, cnt2},   128'd15);
        chk("sat cnt16",  {112'h0, cnt0},   128'd20);
        chk("sat pc",     {96'h0, q0_pc},   128'h3024);

        cnt_clr = 1'b1;
        step();
        chk("clr hold cnt",    {112'h0, cnt0},     128'd0);
        chk("clr hold cnt_w4", {124'h0, cnt2},     128'd0);
        chk("clr hold valid",  {127'h0, q0_valid}, 128'd1);

        // reset in the middle of a stall
        cnt_clr = 1'b0;
        for (int i = 0; i < 5; i++) step();
        chk("pre-reset cnt",   {112'h0, cnt0},     128'd5);
        chk("pre-reset valid", {127'h0, q0_valid}, 128'd1);
        reset = 1'b1;
        step();
        chk_zero("mid-stall reset");

        // flush first, then reset together with flush: reset is not a bubble
        reset = 1'b0; flush = 1'b1;
        step();
        chk("flush2 bubble", {127'h0, q0_bubble}, 128'd1);
        reset = 1'b1;
        step();
        chk_zero("mid-flush reset");
        chk("mid-flush reset nokeep bubble", {127'h0, q1_bubble}, 128'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
